// File: rtl/mem_arb_pkg.sv
// Shared types and default limits for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  localparam int MAX_DATA_RUN_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;

endpackage

// File: rtl/mem_arbiter.sv
// Serializes ARM fetch and data requests onto one strobe/done memory port.
// Data wins contention, but a fetch is forced through after MAX_DATA_RUN contested data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_strobe,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done,
  output logic              err
);

  localparam int RUN_W  = $clog2(MAX_DATA_RUN + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MAX_DATA_RUN);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

  arb_state_t        state, state_n;
  grant_t            grant, grant_n;
  logic              go;
  logic              abort;
  logic              forced;
  logic [RUN_W-1:0]  data_run;
  logic [TCNT_W-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    go      = 1'b0;
    abort   = 1'b0;
    forced  = i_req && (data_run == RUN_MAX);
    case (state)
      IDLE: begin
        if (d_req && !forced) begin
          go      = 1'b1;
          grant_n = GRANT_D;
          state_n = ISSUE;
        end else if (i_req) begin
          go      = 1'b1;
          grant_n = GRANT_I;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        // a done arriving on the very cycle the watchdog expires still counts as success
        if (m_done) begin
          state_n = RESP;
        end else if (tcnt == TCNT_MAX) begin
          abort   = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= GRANT_I;
      data_run <= '0;
      tcnt     <= '0;
      m_strobe <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
    end else begin
      m_strobe <= go;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            grant <= grant_n;
            if (grant_n == GRANT_D) begin
              m_addr  <= d_addr;
              m_we    <= d_we;
              m_wdata <= d_wdata;
              if (i_req && data_run != RUN_MAX) data_run <= data_run + 1'b1;
            end else begin
              m_addr   <= i_addr;
              m_we     <= 1'b0;
              m_wdata  <= '0;
              data_run <= '0;
            end
          end
        end
        ISSUE: tcnt <= '0;
        WAIT: begin
          if (state_n == RESP) begin
            if (grant == GRANT_I) begin
              i_done  <= 1'b1;
              i_rdata <= abort ? '0 : m_rdata;
            end else begin
              d_done <= 1'b1;
              if (!m_we) d_rdata <= abort ? '0 : m_rdata;
            end
            if (abort) err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written contention, timeout, reset and back-to-back sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, m_done;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_done, d_done, m_strobe, m_we, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_strobe(m_strobe), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .err(err)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          wt;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[6];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // request presented during the current cycle; memory answers wt cycles after WAIT entry
  task automatic do_txn(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mdata, input int wt,
                        input logic [31:0] exp_rd, input logic exp_err);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    @(negedge clk);
    check1("issue_strobe", m_strobe, 1'b1);
    check32("issue_addr", m_addr, addr);
    check1("issue_we", m_we, we);
    if (we) check32("issue_wdata", m_wdata, wdata);
    @(negedge clk);
    check1("wait_strobe", m_strobe, 1'b0);
    for (int k = 0; k < wt; k++) begin
      @(negedge clk);
      check32("hold_addr", m_addr, addr);
      check1("hold_we", m_we, we);
      if (we) check32("hold_wdata", m_wdata, wdata);
      check1("early_done", i_done | d_done, 1'b0);
    end
    m_done = 1'b1; m_rdata = mdata;
    @(negedge clk);
    m_done = 1'b0; i_req = 1'b0; d_req = 1'b0;
    check1("resp_i_done", i_done, !is_d);
    check1("resp_d_done", d_done, is_d);
    if (is_d) check32("resp_d_rdata", d_rdata, exp_rd);
    else      check32("resp_i_rdata", i_rdata, exp_rd);
    check1("resp_err", err, exp_err);
    @(negedge clk);
    check1("done_one_cycle", i_done | d_done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic exp_is_d[10];
    logic found;

    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_done = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hE3A0_0001, 0, 32'hE3A0_0001};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'h55, 32'hDEAD_0000, 3, 32'hCAFE_F00D};
    tbl[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 32'h1234_5678, 1, 32'h1234_5678};
    tbl[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 8, 32'hFFFF_FFFF};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_0204, 32'hA5A5_A5A5, 32'h0, 0, 32'hFFFF_FFFF};

    repeat (3) @(negedge clk);
    check1("rst_strobe", m_strobe, 1'b0);
    check1("rst_we", m_we, 1'b0);
    check32("rst_addr", m_addr, 32'h0);
    check32("rst_wdata", m_wdata, 32'h0);
    check1("rst_done", i_done | d_done, 1'b0);
    check32("rst_i_rdata", i_rdata, 32'h0);
    check32("rst_d_rdata", d_rdata, 32'h0);
    check1("rst_err", err, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++)
      do_txn(tbl[v].is_d, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].mdata,
             tbl[v].wt, tbl[v].exp_rd, 1'b0);

    // contention: both requests held across ten transactions
    exp_is_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    i_req = 1'b1; i_addr = 32'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int n = 0; n < 10; n++) begin
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        @(negedge clk);
        if (m_strobe) found = 1'b1;
      end
      check1("cont_strobe_seen", found, 1'b1);
      check32("cont_grant_addr", m_addr, exp_is_d[n] ? 32'h2000 : 32'h1000);
      @(negedge clk);
      m_done = 1'b1; m_rdata = 32'(n);
      @(negedge clk);
      m_done = 1'b0;
      check1("cont_i_done", i_done, !exp_is_d[n]);
      check1("cont_d_done", d_done, exp_is_d[n]);
      if (n == 9) begin i_req = 1'b0; d_req = 1'b0; end
    end
    @(negedge clk);

    // timeout: memory never answers
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    @(negedge clk);
    check1("to_strobe", m_strobe, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check1("to_no_done_yet", d_done, 1'b0);
    end
    @(negedge clk);
    d_req = 1'b0;
    check1("to_d_done", d_done, 1'b1);
    check32("to_d_rdata", d_rdata, 32'h0);
    check1("to_err", err, 1'b1);
    @(negedge clk);
    check1("to_err_sticky", err, 1'b1);
    check1("to_done_pulse", d_done, 1'b0);
    do_txn(1'b0, 1'b0, 32'h108, 32'h0, 32'h0BAD_CAFE, 1, 32'h0BAD_CAFE, 1'b1);

    // spurious done in IDLE, then reset in WAIT followed by a late done
    m_done = 1'b1; m_rdata = 32'h66;
    @(negedge clk);
    m_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1("spur_no_strobe", m_strobe, 1'b0);
      check1("spur_no_done", i_done | d_done, 1'b0);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    @(negedge clk);
    check1("rw_strobe", m_strobe, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; d_req = 1'b0; m_done = 1'b1; m_rdata = 32'h77;
    check32("rw_addr_cleared", m_addr, 32'h0);
    check1("rw_err_cleared", err, 1'b0);
    check32("rw_i_rdata", i_rdata, 32'h0);
    check32("rw_d_rdata", d_rdata, 32'h0);
    @(negedge clk);
    m_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check1("late_no_done", i_done | d_done, 1'b0);
      check1("late_no_strobe", m_strobe, 1'b0);
      check32("late_d_rdata", d_rdata, 32'h0);
      @(negedge clk);
    end

    // back-to-back fetch: new address presented the cycle after i_done
    i_req = 1'b1; i_addr = 32'h600;
    @(negedge clk);
    check1("b2b_strobe0", m_strobe, 1'b1);
    check32("b2b_addr0", m_addr, 32'h600);
    @(negedge clk);
    m_done = 1'b1; m_rdata = 32'hAAAA_0001;
    @(negedge clk);
    m_done = 1'b0;
    check1("b2b_done0", i_done, 1'b1);
    check32("b2b_rdata0", i_rdata, 32'hAAAA_0001);
    @(negedge clk);
    i_addr = 32'h604;
    check1("b2b_idle_no_done", i_done, 1'b0);
    check1("b2b_idle_no_strobe", m_strobe, 1'b0);
    @(negedge clk);
    check1("b2b_strobe1", m_strobe, 1'b1);
    check32("b2b_addr1", m_addr, 32'h604);
    @(negedge clk);
    m_done = 1'b1; m_rdata = 32'hAAAA_0002;
    @(negedge clk);
    m_done = 1'b0; i_req = 1'b0;
    check1("b2b_done1", i_done, 1'b1);
    check32("b2b_rdata1", i_rdata, 32'hAAAA_0002);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check1("b2b_no_dup_strobe", m_strobe, 1'b0);
      check1("b2b_no_dup_done", i_done, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter sharing the single strobe/done memory port (the `MemControl` DDR3 path) between the ARM core's instruction-fetch and data ports. It accepts one request per port and serializes them onto the memory with a strobe/done handshake. Data requests have priority, with a bounded-starvation guarantee for fetch. A watchdog detects a memory that never answers. The block sits between `arm` and the memory controller in `top`.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_RUN, 4, consecutive contested data grants before fetch is forced through
- TIMEOUT, 255, WAIT cycles without `m_done` before abort
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, held until `i_done`
- i_addr  in  ADDR_W  fetch address, stable while `i_req`
- i_rdata  out  DATA_W  fetch data, valid with `i_done`
- i_done  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until `d_done`
- d_we  in  1  1 = write
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid with `d_done`
- d_done  out  1  one-cycle completion pulse
- m_strobe  out  1  one-cycle transaction start to memory
- m_we  out  1  memory write enable, held ISSUE..WAIT
- m_addr  out  ADDR_W  memory address, held ISSUE..WAIT
- m_wdata  out  DATA_W  memory write data, held ISSUE..WAIT
- m_rdata  in  DATA_W  memory read data, sampled with `m_done`
- m_done  in  1  memory completion
- err  out  1  sticky timeout flag

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE, arbitration:**
  - If `d_req` and not forced, grant D. Forced means `i_req` and `data_run == MAX_DATA_RUN`.
  - Else if `i_req`, grant I.
  - On grant, latch the grant, `m_addr`, `m_we` (0 for I), and `m_wdata`; go to ISSUE.
- **data_run:**
  - Increments (saturating at MAX_DATA_RUN) on a D grant while `i_req` is high.
  - Clears on any I grant.
  - Unchanged on an uncontested D grant.
- **ISSUE:** `m_strobe` = 1 for exactly this cycle; next state WAIT.
- **WAIT:**
  - `m_done` = 1: capture `m_rdata`, go to RESP.
  - Timeout counter reaches TIMEOUT without `m_done`: set `err`, captured data = 0, go to RESP.
- **RESP:**
  - Granted port's `x_done` = 1 for one cycle; `x_rdata` = captured data.
  - For D writes, `d_rdata` keeps its previous value.
  - Next state IDLE.
- **Requester rules:**
  - A requester must deassert or change its request in the cycle after `done`.
  - A `req` still high in IDLE is treated as a new transaction.
- **m_done:** ignored in IDLE, ISSUE and RESP. A spurious pulse is dropped with no state change.
- **err:** stays high until reset; operation continues normally afterwards.
- **Reset (including mid-transaction):**
  - Next state IDLE; abandon any in-flight memory transaction.
  - All outputs 0, `data_run` = 0, timeout counter 0, `err` = 0.
  - A late `m_done` arriving after reset is ignored.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Request seen at edge ending cycle t (IDLE): ISSUE in t+1, WAIT from t+2.
- `m_done` in cycle t+k (k ≥ 2) gives RESP/done in t+k+1 and IDLE in t+k+2.
- Minimum latency (zero-wait memory, `m_done` in t+2): `done` in t+3.
- Back-to-back throughput: one transaction per 4 cycles at best.
- Timeout: the counter starts at 0 on WAIT entry. Abort happens in the cycle it equals TIMEOUT, so RESP falls TIMEOUT+1 cycles after WAIT entry.
- Both requests arriving in the same IDLE cycle: only one is granted; the loser waits, holding its request.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t`
  - `typedef enum logic {GRANT_I, GRANT_D} grant_t`
  - default constants for MAX_DATA_RUN and TIMEOUT
- Single module; no sub-module warranted.

## Test plan
- **Lone fetch:** `i_req`, `i_addr` = 0x100; memory returns 0xE3A00001 with `m_done` at t+2. Expect `m_strobe` at t+1, `m_addr` = 0x100, `m_we` = 0, `i_done` and `i_rdata` = 0xE3A00001 at t+3, `d_done` never.
- **Data write:** `d_we` = 1, `d_addr` = 0x200, `d_wdata` = 0x55. Expect `m_we` = 1, `m_wdata` = 0x55 held until `m_done`, one `d_done` pulse, `d_rdata` unchanged.
- **Contention:** `i_req` and `d_req` held continuously for 10 transactions. Expect grant order D,D,D,D,I,D,D,D,D,I; `data_run` resets after each I.
- **Timeout:** TIMEOUT = 8, `m_done` never asserted. Expect RESP 9 cycles after WAIT entry, `done` with rdata 0, `err` = 1 and sticky. A following normal transaction completes correctly.
- **Spurious and late done:** `m_done` pulsed in IDLE, then reset asserted during WAIT and `m_done` pulsed the cycle after reset. Expect no `done` output, state IDLE, all outputs 0.
- **Back-to-back fetch:** a new `i_addr` presented the cycle after `i_done`. Expect ISSUE in the following cycle, no lost or duplicated request.
